// File: rtl/riscv_trace_pkg.sv
// Shared types for the RISC-V trace capture block: record type codes, FSM states, header layout.
package riscv_trace_pkg;

  localparam int unsigned IDX_W  = 9;
  localparam int unsigned TYPE_W = 2;

  typedef enum logic [TYPE_W-1:0] {
    TT_REG    = 2'b01,
    TT_MEM_WR = 2'b10,
    TT_MEM_RD = 2'b11
  } trace_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_HALTED
  } state_e;

  // Record header sitting between the optional timestamp and the data word.
  typedef struct packed {
    trace_type_e            typ;
    logic [IDX_W-1:0]       idx;
  } trace_hdr_t;

endpackage

// File: rtl/trace_fifo2w1r.sv
// Dual-push / single-pop register FIFO with a registered head stage; level counts the head too.
module trace_fifo2w1r #(
  parameter  int unsigned W     = 43,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push0,
  input  logic          push1,
  input  logic [W-1:0]  din0,
  input  logic [W-1:0]  din1,
  input  logic          pop_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          ov_q, ov_d;
  logic [W-1:0]  od_q, od_d;
  logic          pop;
  logic          load;

  // push1 is only ever asserted together with push0; it lands in the slot after push0.
  always_comb begin
    pop      = ov_q && pop_ready;
    load     = (cnt_q != '0) && (!ov_q || pop_ready);
    mem_d    = mem_q;
    if (push0) mem_d[wr_ptr_q] = din0;
    if (push1) mem_d[wr_ptr_q + AW'(1)] = din1;
    wr_ptr_d = wr_ptr_q + AW'(push0) + AW'(push1);
    rd_ptr_d = rd_ptr_q + AW'(load);
    cnt_d    = cnt_q + LW'(push0) + LW'(push1) - LW'(load);
    ov_d     = load || (ov_q && !pop);
    od_d     = load ? mem_q[rd_ptr_q] : od_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ov_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ov_q     <= 1'b0;
      od_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign level     = cnt_q + LW'(ov_q);

endmodule

// File: rtl/riscv_trace_capture.sv
// Captures RISC-V writeback and data-memory trace events into a buffered valid/ready record stream.
// Optional per-record cycle stamp enabled by defining RISCV_TRACE_TIMESTAMP_EN.
module riscv_trace_capture
  import riscv_trace_pkg::*;
#(
  parameter  int unsigned DATA_W       = 32,
  parameter  int unsigned DEPTH        = 16,
  parameter  int unsigned TS_W         = 16,
  parameter  bit          STOP_ON_FULL = 1'b0,
`ifdef RISCV_TRACE_TIMESTAMP_EN
  localparam int unsigned REC_W        = TS_W + TYPE_W + IDX_W + DATA_W,
`else
  localparam int unsigned REC_W        = TYPE_W + IDX_W + DATA_W,
`endif
  localparam int unsigned LVL_W        = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              trace_en,
  input  logic              trace_clr,
  input  logic              reg_write_sig,
  input  logic [4:0]        reg_num,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              wr,
  input  logic              rd,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REC_W-1:0]  out_record,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  output logic [15:0]       drop_count
);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || TS_W == 0) begin : g_bad_cfg
    $error("riscv_trace_capture: DEPTH must be a power of two >= 4 and TS_W nonzero");
  end

  state_e            state_q, state_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_count_q, drop_count_d;
  logic              cap, mem_ev, reg_ev;
  logic              push0, push1;
  logic [1:0]        n_ev, n_push, n_drop;
  logic [LVL_W-1:0]  free;
  logic [16:0]       drop_sum;
  trace_hdr_t        mem_hdr, reg_hdr;
  logic [REC_W-1:0]  rec_mem, rec_reg, rec0;

`ifdef RISCV_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0]   ts_q, ts_d;

  always_comb begin
    ts_d = trace_clr ? '0 : ts_q + TS_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_d;
  end
`endif

  // free is taken from the pre-pop level, so a same-cycle pop never makes room.
  always_comb begin
    cap     = (state_q == ST_CAPTURE) && !trace_clr;
    mem_ev  = cap && (wr || rd);
    reg_ev  = cap && reg_write_sig && (reg_num != '0);
    free    = LVL_W'(DEPTH) - level;
    n_ev    = {1'b0, mem_ev} + {1'b0, reg_ev};
    push0   = (n_ev != 2'd0) && (free != '0);
    push1   = (n_ev == 2'd2) && (free >= LVL_W'(2));
    n_push  = {1'b0, push0} + {1'b0, push1};
    n_drop  = n_ev - n_push;

    mem_hdr = '{typ: (wr ? TT_MEM_WR : TT_MEM_RD), idx: addr};
    reg_hdr = '{typ: TT_REG, idx: {4'b0000, reg_num}};
`ifdef RISCV_TRACE_TIMESTAMP_EN
    rec_mem = {ts_q, mem_hdr, (wr ? wr_data : rd_data)};
    rec_reg = {ts_q, reg_hdr, reg_data};
`else
    rec_mem = {mem_hdr, (wr ? wr_data : rd_data)};
    rec_reg = {reg_hdr, reg_data};
`endif
    rec0    = mem_ev ? rec_mem : rec_reg;

    drop_sum     = {1'b0, drop_count_q} + 17'(n_drop);
    drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    overflow_d   = overflow_q || (n_drop != 2'd0);

    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (trace_en) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (STOP_ON_FULL && (n_drop != 2'd0)) state_d = ST_HALTED;
        else if (!trace_en)                   state_d = ST_IDLE;
      end
      ST_HALTED:  state_d = ST_HALTED;
      default:    state_d = ST_IDLE;
    endcase

    if (trace_clr) begin
      state_d      = ST_IDLE;
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  trace_fifo2w1r #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .clr       (trace_clr),
    .push0     (push0),
    .push1     (push1),
    .din0      (rec0),
    .din1      (rec_reg),
    .pop_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_record),
    .level     (level)
  );

  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule
